// File: rtl/reg_xfer_pkg.sv
// Shared helpers for the register-transfer arbiter: channel index width
// derivation and round-robin pointer advance.
package reg_xfer_pkg;

    function automatic int calc_cw(input int n);
        return (n > 32'sd2) ? $clog2(n) : 32'sd1;
    endfunction

    function automatic int next_ptr(input int k, input int n);
        return (k >= n - 32'sd1) ? 32'sd0 : k + 32'sd1;
    endfunction

endpackage

// File: rtl/reg_xfer_arb_rr_arb.sv
// Round-robin channel selector: combinational pick starting at a registered
// priority pointer that moves past each granted channel.
module rr_arb
    import reg_xfer_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = calc_cw(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    output logic [CW-1:0]  ptr,
    input  logic           adv,
    output logic           gnt_vld,
    output logic [CW-1:0]  gnt_idx
);

    logic [CW-1:0] ptr_r;
    logic [CW-1:0] cand_s;

    // Scan downward so the requester closest to the pointer is written last and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = {CW{1'b0}};
        cand_s  = {CW{1'b0}};
        for (int off = NCH - 1; off >= 0; off--) begin
            cand_s  = CW'((int'(ptr_r) + off) % NCH);
            gnt_vld = gnt_vld | req[cand_s];
            gnt_idx = req[cand_s] ? cand_s : gnt_idx;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {CW{1'b0}};
        end else if (adv && gnt_vld) begin
            ptr_r <= CW'(next_ptr(int'(gnt_idx), NCH));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/reg_xfer_arb.sv
// Per-channel shadow registers drained one word per cycle through a
// round-robin arbiter. Optional sticky overrun flags: REG_XFER_OVF_EN.
module reg_xfer_arb
    import reg_xfer_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    localparam int CW    = calc_cw(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_strobe,
    input  logic [NCH*WIDTH-1:0] in_reg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_reg,
    output logic [CW-1:0]        out_chan,
    output logic [NCH-1:0]       pending,
    output logic [NCH-1:0]       ovf,
    input  logic [NCH-1:0]       ovf_clr
);

    logic [WIDTH-1:0] shadow_r [NCH];
    logic [NCH-1:0]   pending_r;
    logic [NCH-1:0]   pending_nxt_s;
    logic [NCH-1:0]   gnt_onehot_s;
    logic [NCH-1:0]   ovf_set_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_reg_r;
    logic [CW-1:0]    out_chan_r;
    logic             free_s;
    logic             grant_s;
    logic             gnt_vld_s;
    logic [CW-1:0]    gnt_idx_s;
    logic [CW-1:0]    unused_rr_ptr_s;

    assign free_s  = ~out_valid_r | out_ready;
    assign grant_s = free_s & gnt_vld_s;

    rr_arb #(.NCH(NCH)) u_rr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pending_r),
        .ptr     (unused_rr_ptr_s),
        .adv     (grant_s),
        .gnt_vld (gnt_vld_s),
        .gnt_idx (gnt_idx_s)
    );

    // A strobe landing on the granted channel reloads it without counting as an overrun.
    always_comb begin
        gnt_onehot_s  = {NCH{1'b0}};
        pending_nxt_s = pending_r;
        ovf_set_s     = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            gnt_onehot_s[i]  = grant_s & (gnt_idx_s == CW'(i));
            pending_nxt_s[i] = in_strobe[i] | (pending_r[i] & ~gnt_onehot_s[i]);
            ovf_set_s[i]     = in_strobe[i] & pending_r[i] & ~gnt_onehot_s[i];
        end
    end

    // Shadow capture; contents are don't-care until pending is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst && in_strobe[i]) begin
                shadow_r[i] <= in_reg[i*WIDTH +: WIDTH];
            end else begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    // Pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {NCH{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Output stage: load on grant, drop valid only on acceptance without a new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_reg_r   <= {WIDTH{1'b0}};
            out_chan_r  <= {CW{1'b0}};
        end else if (grant_s) begin
            out_valid_r <= 1'b1;
            out_reg_r   <= shadow_r[gnt_idx_s];
            out_chan_r  <= gnt_idx_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_reg_r   <= out_reg_r;
            out_chan_r  <= out_chan_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_reg_r   <= out_reg_r;
            out_chan_r  <= out_chan_r;
        end
    end

`ifdef REG_XFER_OVF_EN
    logic [NCH-1:0] ovf_r;

    // Sticky overrun flags; a new overrun beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= {NCH{1'b0}};
        end else begin
            ovf_r <= ovf_set_s | (ovf_r & ~ovf_clr);
        end
    end

    assign ovf = ovf_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ^{ovf_clr, ovf_set_s};
    assign ovf          = {NCH{1'b0}};
`endif

    assign out_valid = out_valid_r;
    assign out_reg   = out_reg_r;
    assign out_chan  = out_chan_r;
    assign pending   = pending_r;

endmodule

// File: tb/tb_reg_xfer_arb.sv
// Self-checking bench for reg_xfer_arb (NCH=4, WIDTH=32): a per-cycle vector
// table followed by scoreboarded multi-cycle sequences.
module tb_reg_xfer_arb;

    localparam int NCH   = 4;
    localparam int WIDTH = 32;
`ifdef REG_XFER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       in_strobe;
    logic [NCH*WIDTH-1:0] in_reg;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_reg;
    logic [1:0]           out_chan;
    logic [NCH-1:0]       pending;
    logic [NCH-1:0]       ovf;
    logic [NCH-1:0]       ovf_clr;

    reg_xfer_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_strobe (in_strobe),
        .in_reg    (in_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_reg   (out_reg),
        .out_chan  (out_chan),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  stb;
        logic [31:0] dat;
        logic        rdy;
        logic        exp_vld;
        logic [1:0]  exp_chan;
        logic [31:0] exp_reg;
        logic [3:0]  exp_pend;
    } vec_t;

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] data;
    } word_t;

    vec_t  vecs [9];
    word_t sb [$];
    int    errors = 0;
    int    checks = 0;
    bit    sb_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d);
        word_t w;
        w.chan = ch;
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic set_ch(input int ch, input logic [31:0] d);
        in_reg[ch*WIDTH +: WIDTH] = d;
        in_strobe[ch] = 1'b1;
    endtask

    // Advance one clock; a word accepted at this edge is checked against the scoreboard.
    task automatic tick();
        word_t w;
        if (sb_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got chan %0d data %0h expected no word", out_chan, out_reg);
            end else begin
                w = sb.pop_front();
                chk("sb_chan", 64'(out_chan), 64'(w.chan));
                chk("sb_data", 64'(out_reg), 64'(w.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, strobe, data, ready | valid, chan, reg, pending
        vecs[0] = '{1'b1, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 4'b0000};
        vecs[1] = '{1'b0, 4'b0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 4'b0100};
        vecs[2] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000};
        vecs[3] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 4'b0000};
        vecs[4] = '{1'b0, 4'b1001, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 4'b1001};
        vecs[5] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 2'd3, 32'h1234_5678, 4'b0001};
        vecs[6] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 2'd3, 32'h1234_5678, 4'b0001};
        vecs[7] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 32'h1234_5678, 4'b0000};
        vecs[8] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 4'b0000};

        rst = 1'b1;
        in_strobe = '0;
        in_reg = '0;
        out_ready = 1'b1;
        ovf_clr = '0;

        for (int i = 0; i < 9; i++) begin
            rst       = vecs[i].rst;
            in_strobe = vecs[i].stb;
            in_reg    = {NCH{vecs[i].dat}};
            out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_pend", i), 64'(pending), 64'(vecs[i].exp_pend));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'd0);
            if (vecs[i].exp_vld || vecs[i].rst) begin
                chk($sformatf("vec%0d_chan", i), 64'(out_chan), 64'(vecs[i].exp_chan));
                chk($sformatf("vec%0d_reg", i), 64'(out_reg), 64'(vecs[i].exp_reg));
            end
        end
        in_strobe = '0;
        out_ready = 1'b1;
        sb_en = 1'b1;

        // All four channels at once drain in order 0..3 with no gaps.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            set_ch(ch, 32'hA000_0000 + 32'(ch));
            push(2'(ch), 32'hA000_0000 + 32'(ch));
        end
        tick();
        in_strobe = '0;
        chk("all_pend", 64'(pending), 64'hF);
        tick();
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("burst%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("burst%0d_chan", k), 64'(out_chan), 64'(k));
            tick();
        end
        chk("burst_done", 64'(out_valid), 64'd0);

        // Coalescing under back-pressure, set-wins on clear, then clear.
        out_ready = 1'b0;
        set_ch(0, 32'h5A5A_0000);
        push(2'd0, 32'h5A5A_0000);
        tick();
        in_strobe = '0;
        tick();
        chk("stall_valid", 64'(out_valid), 64'd1);
        set_ch(1, 32'h0000_0011);
        tick();
        set_ch(1, 32'h0000_0022);
        push(2'd1, 32'h0000_0022);
        tick();
        chk("ovf_set", 64'(ovf), 64'({2'b00, OVF_EN, 1'b0}));
        set_ch(1, 32'h0000_0022);
        ovf_clr = 4'b0010;
        tick();
        in_strobe = '0;
        ovf_clr = '0;
        chk("ovf_set_wins", 64'(ovf), 64'({2'b00, OVF_EN, 1'b0}));
        chk("stall_pend", 64'(pending), 64'b0010);
        chk("hold_reg", 64'(out_reg), 64'h5A5A_0000);
        chk("hold_chan", 64'(out_chan), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("coal_chan", 64'(out_chan), 64'd1);
        chk("coal_reg", 64'(out_reg), 64'h22);
        tick();
        chk("coal_single", 64'(out_valid), 64'd0);
        chk("coal_pend", 64'(pending), 64'd0);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        chk("ovf_clr", 64'(ovf), 64'd0);

        // Strobe on a channel in its grant cycle.
        set_ch(3, 32'h0000_0333);
        push(2'd3, 32'h0000_0333);
        tick();
        set_ch(3, 32'h0000_0444);
        push(2'd3, 32'h0000_0444);
        tick();
        in_strobe = '0;
        chk("same_old", 64'(out_reg), 64'h333);
        chk("same_pend", 64'(pending), 64'b1000);
        chk("same_ovf", 64'(ovf), 64'd0);
        tick();
        chk("same_new", 64'(out_reg), 64'h444);
        chk("same_new_chan", 64'(out_chan), 64'd3);
        tick();
        chk("same_done", 64'(out_valid), 64'd0);

        // Reset mid-transfer discards everything and restarts the pointer at 0.
        out_ready = 1'b0;
        set_ch(1, 32'h0101_0101);
        tick();
        in_strobe = '0;
        tick();
        set_ch(0, 32'h0000_00A0);
        set_ch(2, 32'h0000_00A2);
        set_ch(3, 32'h0000_00A3);
        tick();
        in_strobe = '0;
        chk("pre_rst_pend", 64'(pending), 64'b1101);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        set_ch(1, 32'hBAD0_0001);
        tick();
        rst = 1'b0;
        in_strobe = '0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pend", 64'(pending), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_chan", 64'(out_chan), 64'd0);
        chk("rst_reg", 64'(out_reg), 64'd0);
        tick();
        chk("rst_strobe_ignored", 64'(pending), 64'd0);
        out_ready = 1'b1;
        set_ch(3, 32'h3333_0003);
        set_ch(1, 32'h1111_0001);
        push(2'd1, 32'h1111_0001);
        push(2'd3, 32'h3333_0003);
        tick();
        in_strobe = '0;
        tick();
        chk("post_rst_first", 64'(out_chan), 64'd1);
        tick();
        chk("post_rst_second", 64'(out_chan), 64'd3);
        tick();
        chk("post_rst_done", 64'(out_valid), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_xfer_arb.md
REG_XFER_ARB -- requirements
Module: reg_xfer_arb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 32: per-channel register width in bits (1 to 64).
REQ-003 The block SHALL have parameter NCH, default 4: channel count (2 to 16).
REQ-004 The block SHALL have derived constant CW = max(1, clog2(NCH)): the channel index width.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_strobe  in  NCH  per-channel load strobe, one cycle each
- in_reg  in  NCH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_reg  out  WIDTH  output data
- out_chan  out  CW  source channel of out_reg
- pending  out  NCH  channel holds an untransferred value
- ovf  out  NCH  sticky per-channel overrun flag
- ovf_clr  in  NCH  clears the matching ovf bit

Function
REQ-006 On in_strobe[i], channel i's shadow register SHALL capture in_reg slice i and set pending[i] on the next cycle.
REQ-007 A strobe on a channel that is already pending SHALL overwrite the shadow (latest value wins), keep pending set, and set ovf[i].
REQ-008 Same-cycle strobe and grant on channel i: the granted word SHALL be the old shadow, the new value SHALL load, pending[i] SHALL stay 1, and ovf[i] SHALL NOT be set.
REQ-009 The output stage SHALL be "free" when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-010 When the output stage is free and any pending bit is set, a round-robin arbiter SHALL grant one channel.
REQ-011 On a grant, the arbiter SHALL load out_reg and out_chan, set out_valid, and clear that channel's pending bit (subject to REQ-008), all in the same edge.
REQ-012 Round-robin SHALL start at channel 0 after reset; after granting channel k, highest priority SHALL move to (k+1) mod NCH.
REQ-013 out_reg and out_chan SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 out_valid SHALL drop only on acceptance with no new grant.
REQ-015 Latency from strobe (cycle t) to out_valid SHALL be 2 cycles (t+2) when the output stage is idle.
REQ-016 Throughput SHALL be one word per cycle with out_ready held at 1.
REQ-017 Back-to-back acceptances SHALL introduce no bubble.
REQ-018 Simultaneous ovf_clr[i] and a new overrun on channel i SHALL leave ovf[i]=1 (set wins).

Reset
REQ-019 rst SHALL force out_valid=0, pending=0, ovf=0, out_chan=0, out_reg=0, and the round-robin pointer to 0.
REQ-020 Shadow register contents need not be reset.
REQ-021 rst asserted mid-transfer SHALL discard all pending and in-flight words.
REQ-022 Strobes in the rst cycle SHALL be ignored.

Configuration
REQ-023 With macro REG_XFER_OVF_EN defined, ovf and ovf_clr SHALL behave per REQ-007 and REQ-018.
REQ-024 Without REG_XFER_OVF_EN, ovf SHALL be tied to 0, ovf_clr SHALL be ignored, and no overrun flops SHALL be built.
REQ-025 Coalescing (REQ-007) SHALL be unchanged whether or not REG_XFER_OVF_EN is defined.

Structure
REQ-026 The CW derivation function and the pointer-advance helper SHALL live in shared package reg_xfer_pkg.
REQ-027 Round-robin selection SHALL be a sub-module rr_arb, parameter NCH, with ports req[NCH], ptr[CW], adv, gnt_vld, gnt_idx[CW].
REQ-028 rr_arb SHALL be combinational select plus a registered pointer.

Verification
REQ-029 NCH=4, WIDTH=32: strobe ch2 with 0xDEADBEEF at t, out_ready=1 -> out_valid=1 at t+2, out_reg=0xDEADBEEF, out_chan=2, pending=0 at t+3.
REQ-030 Strobe ch0-ch3 in one cycle, out_ready=1 -> words out in order ch0, ch1, ch2, ch3 on four consecutive cycles, no gaps.
REQ-031 out_ready=0, ch1 strobed with 0x11 then 0x22 -> ovf[1]=1, a single word 0x22 delivered after out_ready=1, and ovf_clr[1] then clears ovf[1].
REQ-032 Strobe ch3 in the same cycle it is granted -> old value delivered, new value delivered next, ovf[3]=0.
REQ-033 rst pulse with 3 channels pending and out_valid=1 -> next cycle all outputs 0, and the next grant goes to the lowest strobed channel from pointer 0.
REQ-034 Build without REG_XFER_OVF_EN, repeat the REQ-031 stimulus -> ovf stays 0 and the delivered word is still 0x22.
